// File: rtl/dmem_arbiter_pkg.sv
// Shared width and FSM state encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE   = 2'd0,
    DMEM_ARB_ACCESS = 2'd1,
    DMEM_ARB_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-input grant logic. DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
// via the `last` register; otherwise port 0 always wins ties.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last = index of the most recent winner; resets to 1 so port 0 wins the first tie
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt = 2'b00;
    if (en) gnt = req[0] ? 2'b01 : req;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the core port (0) and a loader/debug port (1).
// Tie-break policy is set by DMEM_ARB_ROUND_ROBIN_EN inside rr_arbiter2.
// Handshake: a port holds req and fields stable until gnt; the grant takes the
// transaction, memory is accessed the next cycle and rvalid pulses the cycle after.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic [XLEN-1:0] m1_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [1:0]      dbg_state
);

  arb_state_t      state, state_nxt;
  logic [1:0]      gnt;
  logic            arb_en;
  logic            cap_we;
  logic            owner;
  logic [XLEN-1:0] cap_addr;
  logic [XLEN-1:0] cap_wdata;

  // No arbitration while the memory is busy or during reset
  assign arb_en = (state != DMEM_ARB_ACCESS) && !rst;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= DMEM_ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DMEM_ARB_IDLE,
      DMEM_ARB_RESP:   state_nxt = (|gnt) ? DMEM_ARB_ACCESS : DMEM_ARB_IDLE;
      DMEM_ARB_ACCESS: state_nxt = DMEM_ARB_RESP;
      default:         state_nxt = DMEM_ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    if (state == DMEM_ARB_ACCESS) begin
      mem_addr  = cap_addr;
      mem_wdata = cap_wdata;
      // reset in the access cycle must not commit a write
      mem_we    = cap_we && !rst;
      mem_re    = !cap_we && !rst;
    end
    if (state == DMEM_ARB_RESP && !rst) begin
      m0_rvalid = !owner;
      m1_rvalid = owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      owner     <= 1'b0;
    end else if (|gnt) begin
      cap_we    <= gnt[1] ? m1_we    : m0_we;
      cap_addr  <= gnt[1] ? m1_addr  : m0_addr;
      cap_wdata <= gnt[1] ? m1_wdata : m0_wdata;
      owner     <= gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == DMEM_ARB_ACCESS) begin
      if (owner) m1_rdata <= cap_we ? '0 : mem_rdata;
      else       m0_rdata <= cap_we ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level model checked every cycle.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [1:0]  dbg_state;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;
  int we_cnt = 0;
  int grant_q[$];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h11;
  endfunction

  // data memory: asynchronous read, write at the clock edge
  logic [31:0] mem_q [0:63];
  assign mem_rdata = mem_q[mem_addr[7:2]];
  initial begin
    for (int i = 0; i < 64; i++) mem_q[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem_q[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // behavioural model and per-cycle compare
  logic [31:0] mm [0:63];
  logic [31:0] exp_q[$];
  logic [31:0] rd [2];
  bit          busy, acc_we, resp_pending;
  int          acc_port, resp_port, last_win;
  logic [31:0] acc_addr, acc_wdata;

  initial begin
    int win;
    logic [31:0] d, ed;
    for (int i = 0; i < 64; i++) mm[i] = init_val(i);
    busy = 0; resp_pending = 0; last_win = 1; rd[0] = '0; rd[1] = '0;
    acc_port = 0; resp_port = 0; acc_we = 0; acc_addr = '0; acc_wdata = '0;
    forever begin
      @(negedge clk);
      win = -1;
      if (!rst && !busy) begin
        if (m0_req && m1_req) win = RR ? ((last_win == 1) ? 0 : 1) : 0;
        else if (m0_req)      win = 0;
        else if (m1_req)      win = 1;
      end
      check("m0_gnt", 32'(m0_gnt), 32'(win == 0));
      check("m1_gnt", 32'(m1_gnt), 32'(win == 1));
      check("m0_rvalid", 32'(m0_rvalid), 32'(resp_pending && !rst && resp_port == 0));
      check("m1_rvalid", 32'(m1_rvalid), 32'(resp_pending && !rst && resp_port == 1));
      check("m0_rdata_hold", m0_rdata, rd[0]);
      check("m1_rdata_hold", m1_rdata, rd[1]);
      if (resp_pending && !rst) begin
        ed = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        check("resp_rdata", (resp_port == 0) ? m0_rdata : m1_rdata, ed);
      end
      check("mem_we", 32'(mem_we), 32'(busy && acc_we && !rst));
      check("mem_re", 32'(mem_re), 32'(busy && !acc_we && !rst));
      if (busy && !rst) begin
        check("mem_addr", mem_addr, acc_addr);
        if (acc_we) check("mem_wdata", mem_wdata, acc_wdata);
      end
      if (m0_gnt) grant_q.push_back(0);
      if (m1_gnt) grant_q.push_back(1);
      if (mem_we) we_cnt++;
      // advance the model across the coming clock edge
      if (rst) begin
        busy = 0; resp_pending = 0; last_win = 1;
        rd[0] = '0; rd[1] = '0; exp_q.delete();
      end else begin
        resp_pending = busy;
        resp_port    = acc_port;
        if (busy) begin
          d = acc_we ? 32'h0 : mm[acc_addr[7:2]];
          if (acc_we) mm[acc_addr[7:2]] = acc_wdata;
          rd[acc_port] = d;
          exp_q.push_back(d);
        end
        busy = (win >= 0);
        if (win >= 0) begin
          acc_port  = win;
          acc_we    = (win == 0) ? m0_we : m1_we;
          acc_addr  = (win == 0) ? m0_addr : m1_addr;
          acc_wdata = (win == 0) ? m0_wdata : m1_wdata;
          last_win  = win;
        end
      end
    end
  end

  // driver: raise a request, hold until granted, return during the RESP cycle
  task automatic port_txn(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    int n = 0;
    logic g = 1'b0;
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    do begin
      @(negedge clk);
      g = (p == 0) ? m0_gnt : m1_gnt;
      n++;
    end while (!g && n < 40);
    if (!g) begin
      vecs++; errs++;
      $display("FAIL grant_timeout port %0d: no gnt after %0d cycles, expected a gnt", p, n);
    end
    @(posedge clk); #1;
    if (p == 0) m0_req = 0; else m1_req = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    logic [31:0] gexp [8];
    rst = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_rdata", m0_rdata | m1_rdata, 32'h0);
    @(posedge clk); #1;

    // single read on port 0
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk); check("t1_gnt", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1 m0_req = 0;
    @(negedge clk); check("t1_mem_re", 32'(mem_re), 32'd1);
    check("t1_mem_addr", mem_addr, 32'h10);
    @(posedge clk); #1;
    @(negedge clk); check("t1_rvalid", 32'(m0_rvalid), 32'd1);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // write then read on port 1
    we_cnt = 0;
    port_txn(1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk); check("t2_wack", 32'(m1_rvalid), 32'd1);
    check("t2_wack_rdata", m1_rdata, 32'h0);
    check("t2_we_cycles", 32'(we_cnt), 32'd1);
    @(posedge clk); #1;
    port_txn(1, 1'b0, 32'h20, 32'h0);
    @(negedge clk); check("t2_rdata", m1_rdata, 32'h12345678);
    @(posedge clk); #1;

    // continuous simultaneous requests from a fresh reset
    rst = 1; @(posedge clk); #1 rst = 0;
    grant_q.delete();
    fork
      begin for (int k = 0; k < 4; k++) port_txn(0, 1'b0, 32'(4 * k), 32'h0); end
      begin for (int k = 0; k < 4; k++) port_txn(1, 1'b0, 32'h40 + 32'(4 * k), 32'h0); end
    join
    repeat (2) @(posedge clk); #1;
    if (RR) gexp = '{0, 1, 0, 1, 0, 1, 0, 1};
    else    gexp = '{0, 0, 0, 0, 1, 1, 1, 1};
    check("t4_grant_count", 32'(grant_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_q.size(); k++)
      check($sformatf("t4_grant_%0d", k), 32'(grant_q[k]), gexp[k]);

    // reset during the ACCESS cycle of a write
    m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'hFFFFFFFF;
    @(negedge clk); check("t5_gnt", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1 m0_req = 0; m0_we = 0; rst = 1;
    @(negedge clk); check("t5_we_gated", 32'(mem_we), 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("t5_state", 32'(dbg_state), 32'd0);
    check("t5_rvalid", 32'(m0_rvalid), 32'd0);
    check("t5_mem_addr", mem_addr, 32'h0);
    check("t5_mem_wdata", mem_wdata, 32'h0);
    check("t5_mem_kept", mem_q[12], 32'h100000CC);
    @(posedge clk); #1;

    // new request arriving during RESP is granted alongside the rvalid
    port_txn(0, 1'b0, 32'h08, 32'h0);
    m1_req = 1; m1_we = 0; m1_addr = 32'h44;
    @(negedge clk);
    check("t6_rvalid", 32'(m0_rvalid), 32'd1);
    check("t6_gnt_same_cycle", 32'(m1_gnt), 32'd1);
    @(posedge clk); #1 m1_req = 0;
    repeat (2) @(posedge clk); #1;

    // reset during RESP suppresses rvalid
    m1_req = 1; m1_addr = 32'h48;
    @(negedge clk);
    @(posedge clk); #1 m1_req = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk); check("t7_rvalid_suppressed", 32'(m1_rvalid), 32'd0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
